i2c_slave_bus_controller: RTL and testbench

- Bus-level sequencer for the I2C slave.
- Synchronises raw SCL/SDA and publishes the sampled SCL/SCL_prev/SDA/SDA_prev that the data-in block consumes.
- Detects START and STOP, receives and matches the address byte, and generates ACK/NACK on SDA.
- Gates the data-in block with `enable` for write transfers and the data-out block for read transfers, counts accepted bytes, and flags frame completion and overflow.

---
 rtl/i2c_slave_bus_controller.sv | 186 ++++++++++++++++++
 tb/tb_i2c_slave_bus_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_bus_controller.sv
// I2C slave bus sequencer: synchronises SCL/SDA, detects START/STOP, matches the
// address, generates ACK/NACK and gates the data-in / data-out blocks.
module i2c_slave_bus_controller #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NUM_BYTES  = 6,
  parameter int         BYTE_CNT_W = 4
) (
  input  logic                  FPGA_clk,
  input  logic                  rst,
  input  logic                  SCL_raw,
  input  logic                  SDA_raw,
  output logic                  SCL,
  output logic                  SCL_prev,
  output logic                  SDA,
  output logic                  SDA_prev,
  output logic                  sda_pull_low,
  output logic                  rx_enable,
  output logic                  tx_enable,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam logic [BYTE_CNT_W-1:0] L_MAX_BYTES = BYTE_CNT_W'(NUM_BYTES);
  localparam logic [BYTE_CNT_W-1:0] L_ONE       = BYTE_CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA_RX,
    DATA_ACK,
    READ,
    WAIT_STOP
  } state_t;

  logic r_sclMeta, r_sclSync, r_sclPrev;
  logic r_sdaMeta, r_sdaSync, r_sdaPrev;

  state_t                r_state;
  logic [7:0]            r_shift;
  logic [2:0]            r_bitCnt;
  logic                  r_phaseDone;
  logic                  r_rw;
  logic                  r_pullLow;
  logic                  r_rxEnable;
  logic                  r_txEnable;
  logic [BYTE_CNT_W-1:0] r_byteCount;
  logic                  r_busy;
  logic                  r_frameDone;
  logic                  r_overflow;

  logic w_sclRise, w_sclFall, w_start, w_stop;

  // Two-flop synchronisers plus one history flop; reset to the idle-bus level.
  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      r_sclMeta <= 1'b1;
      r_sclSync <= 1'b1;
      r_sclPrev <= 1'b1;
      r_sdaMeta <= 1'b1;
      r_sdaSync <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclMeta <= SCL_raw;
      r_sclSync <= r_sclMeta;
      r_sclPrev <= r_sclSync;
      r_sdaMeta <= SDA_raw;
      r_sdaSync <= r_sdaMeta;
      r_sdaPrev <= r_sdaSync;
    end
  end

  assign w_sclRise = r_sclSync & ~r_sclPrev;
  assign w_sclFall = ~r_sclSync & r_sclPrev;
  assign w_start   = r_sclSync & r_sclPrev & r_sdaPrev & ~r_sdaSync;
  assign w_stop    = r_sclSync & r_sclPrev & ~r_sdaPrev & r_sdaSync;

  // r_phaseDone marks that the 8th (collect states) or 9th (ACK states) rise has
  // been seen, so the following fall closes the phase.
  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shift     <= 8'h00;
      r_bitCnt    <= 3'd0;
      r_phaseDone <= 1'b0;
      r_rw        <= 1'b0;
      r_pullLow   <= 1'b0;
      r_rxEnable  <= 1'b0;
      r_txEnable  <= 1'b0;
      r_byteCount <= '0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      r_overflow  <= 1'b0;
      if (w_start) begin
        r_state     <= ADDR;
        r_bitCnt    <= 3'd0;
        r_phaseDone <= 1'b0;
        r_byteCount <= '0;
        r_busy      <= 1'b1;
        r_pullLow   <= 1'b0;
        r_rxEnable  <= 1'b0;
        r_txEnable  <= 1'b0;
      end else if (w_stop) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_pullLow   <= 1'b0;
        r_rxEnable  <= 1'b0;
        r_txEnable  <= 1'b0;
        r_phaseDone <= 1'b0;
        if (!r_rw && (r_byteCount != '0)) begin
          r_frameDone <= 1'b1;
        end
      end else begin
        case (r_state)
          ADDR, DATA_RX: begin
            if (w_sclRise) begin
              r_shift  <= {r_shift[6:0], r_sdaSync};
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                r_phaseDone <= 1'b1;
              end
            end else if (w_sclFall && r_phaseDone) begin
              r_phaseDone <= 1'b0;
              if (r_state == ADDR) begin
                r_rw <= r_shift[0];
                if (r_shift[7:1] == SLAVE_ADDR) begin
                  r_state   <= ADDR_ACK;
                  r_pullLow <= 1'b1;
                end else begin
                  r_state   <= WAIT_STOP;
                  r_pullLow <= 1'b0;
                end
              end else if (r_byteCount < L_MAX_BYTES) begin
                r_state     <= DATA_ACK;
                r_pullLow   <= 1'b1;
                r_byteCount <= r_byteCount + L_ONE;
              end else begin
                r_state    <= WAIT_STOP;
                r_pullLow  <= 1'b0;
                r_rxEnable <= 1'b0;
                r_overflow <= 1'b1;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (w_sclRise) begin
              r_phaseDone <= 1'b1;
            end else if (w_sclFall && r_phaseDone) begin
              r_phaseDone <= 1'b0;
              r_pullLow   <= 1'b0;
              r_bitCnt    <= 3'd0;
              if (r_state == DATA_ACK || !r_rw) begin
                r_state    <= DATA_RX;
                r_rxEnable <= 1'b1;
              end else begin
                r_state    <= READ;
                r_txEnable <= 1'b1;
              end
            end
          end
          default: begin
            r_pullLow <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SCL          = r_sclSync;
  assign SCL_prev     = r_sclPrev;
  assign SDA          = r_sdaSync;
  assign SDA_prev     = r_sdaPrev;
  assign sda_pull_low = r_pullLow;
  assign rx_enable    = r_rxEnable;
  assign tx_enable    = r_txEnable;
  assign byte_count   = r_byteCount;
  assign busy         = r_busy;
  assign frame_done   = r_frameDone;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_i2c_slave_bus_controller.sv
// Bench for i2c_slave_bus_controller: a bit-level I2C master drives the bus and a
// frame-level model predicts ACKs, enables, byte counts and pulse totals.
module tb_i2c_slave_bus_controller;

  localparam logic [6:0] SLAVE_ADDR = 7'h42;
  localparam int         NUM_BYTES  = 6;
  localparam int         BYTE_CNT_W = 4;

  logic                  FPGA_clk;
  logic                  rst;
  logic                  SCL_raw;
  logic                  masterSda;
  logic                  SDA_raw;
  logic                  SCL, SCL_prev, SDA, SDA_prev;
  logic                  sda_pull_low, rx_enable, tx_enable;
  logic [BYTE_CNT_W-1:0] byte_count;
  logic                  busy, frame_done, overflow;

  int  vectors     = 0;
  int  miscompares = 0;
  int  doneCount   = 0;
  int  ovfCount    = 0;
  bit  sclHigh     = 1'b1;

  logic                  sPull, sRx, sTx, sBusy;
  logic [BYTE_CNT_W-1:0] sCount;

  // Open-drain bus: either party can pull the line low.
  assign SDA_raw = masterSda & ~sda_pull_low;

  i2c_slave_bus_controller #(
    .SLAVE_ADDR(SLAVE_ADDR),
    .NUM_BYTES (NUM_BYTES),
    .BYTE_CNT_W(BYTE_CNT_W)
  ) dut (
    .FPGA_clk    (FPGA_clk),
    .rst         (rst),
    .SCL_raw     (SCL_raw),
    .SDA_raw     (SDA_raw),
    .SCL         (SCL),
    .SCL_prev    (SCL_prev),
    .SDA         (SDA),
    .SDA_prev    (SDA_prev),
    .sda_pull_low(sda_pull_low),
    .rx_enable   (rx_enable),
    .tx_enable   (tx_enable),
    .byte_count  (byte_count),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial FPGA_clk = 1'b0;
  always #5 FPGA_clk = ~FPGA_clk;

  always @(negedge FPGA_clk) begin
    if (frame_done) doneCount++;
    if (overflow)   ovfCount++;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge FPGA_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic busStart();
    if (!sclHigh) begin
      masterSda = 1'b1;
      waitClk(4);
      SCL_raw = 1'b1;
      waitClk(4);
    end
    masterSda = 1'b0;
    waitClk(4);
    SCL_raw = 1'b0;
    sclHigh = 1'b0;
    waitClk(4);
  endtask

  task automatic busStop();
    masterSda = 1'b0;
    waitClk(4);
    SCL_raw = 1'b1;
    waitClk(4);
    masterSda = 1'b1;
    sclHigh = 1'b1;
    waitClk(6);
  endtask

  task automatic clockBit(input logic b);
    masterSda = b;
    waitClk(4);
    SCL_raw = 1'b1;
    waitClk(4);
    sPull  = sda_pull_low;
    sRx    = rx_enable;
    sTx    = tx_enable;
    sBusy  = busy;
    sCount = byte_count;
    waitClk(4);
    SCL_raw = 1'b0;
    waitClk(4);
  endtask

  // Frame-level expectations: ACK only on a matching address; in a write, data
  // bytes 1..NUM_BYTES are ACKed, byte NUM_BYTES+1 is NACKed with one overflow
  // pulse, and later bytes are ignored.
  task automatic runFrame(input logic [7:0] addrByte, input int nBytes, input bit doStop);
    bit         matched, isWrite, mw;
    int         done0, ovf0, expCount;
    logic [7:0] data;
    matched  = (addrByte[7:1] == SLAVE_ADDR);
    isWrite  = ~addrByte[0];
    mw       = matched & isWrite;
    done0    = doneCount;
    ovf0     = ovfCount;
    expCount = 0;
    busStart();
    check("start_busy", 32'(busy), 32'd1);
    check("start_count", 32'(byte_count), 32'd0);
    for (int b = 7; b >= 0; b--) begin
      clockBit(addrByte[b]);
      check("addr_pull", 32'(sPull), 32'd0);
      check("addr_rx", 32'(sRx), 32'd0);
      check("addr_tx", 32'(sTx), 32'd0);
    end
    clockBit(1'b1);
    check("addr_ack", 32'(sPull), 32'(matched));
    check("addr_ack_busy", 32'(sBusy), 32'd1);
    for (int i = 1; i <= nBytes; i++) begin
      data = isWrite ? 8'($urandom_range(0, 255)) : 8'hFF;
      for (int b = 7; b >= 0; b--) begin
        clockBit(data[b]);
        check("data_pull", 32'(sPull), 32'd0);
        check("data_rx", 32'(sRx), 32'(mw && (i <= NUM_BYTES + 1)));
        check("data_tx", 32'(sTx), 32'(matched && !isWrite));
      end
      if (mw) expCount = (i < NUM_BYTES) ? i : NUM_BYTES;
      clockBit(1'b1);
      check("data_ack", 32'(sPull), 32'(mw && (i <= NUM_BYTES)));
      check("ack_rx", 32'(sRx), 32'(mw && (i <= NUM_BYTES)));
      check("ack_count", 32'(sCount), 32'(expCount));
    end
    check("overflow_pulses", 32'(ovfCount - ovf0), 32'(mw && (nBytes > NUM_BYTES)));
    if (doStop) begin
      busStop();
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_rx", 32'(rx_enable), 32'd0);
      check("stop_tx", 32'(tx_enable), 32'd0);
      check("stop_pull", 32'(sda_pull_low), 32'd0);
      check("stop_count", 32'(byte_count), 32'(expCount));
      check("frame_done_pulses", 32'(doneCount - done0), 32'(mw && (nBytes > 0)));
    end else begin
      check("no_frame_done", 32'(doneCount - done0), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] addr;
    int         sel, n;
    SCL_raw   = 1'b1;
    masterSda = 1'b1;
    rst       = 1'b1;
    #1 rst = 1'b0;
    waitClk(5);
    check("reset_scl", 32'(SCL), 32'd1);
    check("reset_scl_prev", 32'(SCL_prev), 32'd1);
    check("reset_sda", 32'(SDA), 32'd1);
    check("reset_sda_prev", 32'(SDA_prev), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(byte_count), 32'd0);
    check("reset_enables", 32'({rx_enable, tx_enable, sda_pull_low}), 32'd0);
    rst = 1'b1;
    waitClk(4);

    $display("[TB] write frame 0x84 with two bytes");
    runFrame(8'h84, 2, 1'b1);
    $display("[TB] address mismatch 0x86");
    runFrame(8'h86, 2, 1'b1);
    $display("[TB] overflow with seven bytes");
    runFrame(8'h84, 7, 1'b1);
    $display("[TB] read frame 0x85");
    runFrame(8'h85, 2, 1'b1);
    $display("[TB] repeated START");
    runFrame(8'h84, 1, 1'b0);
    runFrame(8'h85, 1, 1'b1);

    $display("[TB] async reset during data bit 4");
    busStart();
    for (int b = 7; b >= 0; b--) clockBit(addr_of(8'h84, b));
    clockBit(1'b1);
    for (int b = 0; b < 3; b++) clockBit(1'b1);
    masterSda = 1'b1;
    waitClk(4);
    SCL_raw = 1'b1;
    waitClk(2);
    check("pre_reset_rx", 32'(rx_enable), 32'd1);
    check("pre_reset_pull", 32'(sda_pull_low), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_rx", 32'(rx_enable), 32'd0);
    check("async_count", 32'(byte_count), 32'd0);
    check("async_lines", 32'({SCL, SCL_prev, SDA, SDA_prev}), 32'hF);
    waitClk(3);
    rst = 1'b1;
    waitClk(4);
    SCL_raw = 1'b0;
    sclHigh = 1'b0;
    waitClk(4);
    busStop();
    check("stop_after_reset_busy", 32'(busy), 32'd0);
    runFrame(8'h84, 1, 1'b1);

    $display("[TB] randomized frames");
    for (int k = 0; k < 10; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       addr = 8'h84;
        1:       addr = 8'h85;
        default: addr = 8'($urandom_range(0, 255));
      endcase
      n = $urandom_range(0, 8);
      runFrame(addr, n, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic addr_of(input logic [7:0] v, input int b);
    return v[b];
  endfunction

endmodule
